echo_pipeline_sequencer: RTL and testbench

Per-sample controller that replaces hand-timed enable pulses around the echo-cancellation datapath. On each sampling tick it drives a handshake through four stages in order:
- 16-bit→double conversion
- lag generation
- either parameter adaptation or echo cancellation, chosen by mode
- output conversion

It also stages the datapath's `enable_sampling` warm-up, flags overruns and timeouts, and counts adaptation iterations.

---
 rtl/echo_seq_pkg.sv | 32 +++
 rtl/seq_stage_timer.sv | 45 ++++
 rtl/echo_pipeline_sequencer.sv | 168 ++++++++++++++++
 tb/tb_echo_pipeline_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_seq_pkg.sv
// Shared types and defaults for the echo-cancellation pipeline sequencer.
// Holds the FSM state encoding, default parameter values and mode constants.
// Imported by the sequencer top and by its stage timer.
package echo_seq_pkg;

    localparam int DEF_CNT_W        = 13;
    localparam int DEF_EN_PULSE     = 2;
    localparam int DEF_MIN_WAIT     = 2;
    localparam int DEF_TIMEOUT      = 1500;
    localparam int DEF_WARMUP_LAG   = 2;
    localparam int DEF_WARMUP_ADAPT = 4;

    localparam logic MODE_ADAPT  = 1'b1;
    localparam logic MODE_CANCEL = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONV_EN   = 3'd1,
        S_CONV_WAIT = 3'd2,
        S_LAG_EN    = 3'd3,
        S_LAG_WAIT  = 3'd4,
        S_PROC_EN   = 3'd5,
        S_PROC_WAIT = 3'd6,
        S_OUTPUT    = 3'd7
    } state_t;

    // True for the states that wait on a stage's ready
    function automatic logic is_wait_state(input state_t s);
        return (s == S_CONV_WAIT) || (s == S_LAG_WAIT) || (s == S_PROC_WAIT);
    endfunction

endpackage

// File: rtl/seq_stage_timer.sv
// Cycle counter shared by the enable-pulse and ready-wait states of the sequencer.
// Latency: flags are combinational on the registered count; load restarts at 0 next cycle.
// No backpressure: counts every cycle and saturates at TIMEOUT.
module seq_stage_timer
    import echo_seq_pkg::*;
#(
    parameter int MIN_WAIT = DEF_MIN_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                           clk_operation,
    input  logic                           rst,
    input  logic                           i_load,
    input  logic [$clog2(TIMEOUT+1)-1:0]   i_limit,
    output logic                           o_pulse_done,
    output logic                           o_wait_ok,
    output logic                           o_timed_out
);

    localparam int              TW          = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   LP_MAX      = TW'(TIMEOUT);
    localparam logic [TW:0]     LP_MIN_WAIT = (TW+1)'(MIN_WAIT);
    localparam logic [TW:0]     LP_TIMEOUT  = (TW+1)'(TIMEOUT);

    logic [TW-1:0] r_cnt;
    logic [TW:0]   w_elapsed;

    // Cycles spent in the current state counting the present one, so a
    // decision taken at the edge sees how long the state will have lasted.
    assign w_elapsed    = {1'b0, r_cnt} + (TW+1)'(1);
    assign o_pulse_done = (w_elapsed >= {1'b0, i_limit});
    assign o_wait_ok    = (w_elapsed >= LP_MIN_WAIT);
    assign o_timed_out  = (w_elapsed >= LP_TIMEOUT);

    // Restart on every state change, otherwise count up and hold at the limit
    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (r_cnt != LP_MAX) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/echo_pipeline_sequencer.sv
// Per-sample sequencer: conv -> lag -> adapt|cancel -> output handshakes on each tick.
// Latency: enable_out 3*(EN_PULSE+MIN_WAIT) cycles after the tick edge with ready high.
// Ticks arriving while busy are dropped and flagged as overrun; waits bounded by TIMEOUT.
module echo_pipeline_sequencer
    import echo_seq_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int EN_PULSE     = DEF_EN_PULSE,
    parameter int MIN_WAIT     = DEF_MIN_WAIT,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int WARMUP_LAG   = DEF_WARMUP_LAG,
    parameter int WARMUP_ADAPT = DEF_WARMUP_ADAPT
) (
    input  logic              clk_operation,
    input  logic              rst,
    input  logic [CNT_W-1:0]  sampling_cycle_counter,
    input  logic              adapt_mode,
    input  logic              clear_err,
    input  logic              ready_conv,
    input  logic              ready_lag,
    input  logic              ready_adapt,
    input  logic              ready_cancel,
    input  logic [63:0]       e,
    input  logic [63:0]       signal_without_echo,
    output logic              enable_conv,
    output logic              enable_lag,
    output logic              enable_adapt,
    output logic              enable_cancel,
    output logic              enable_sampling_lag,
    output logic              enable_sampling_adapt,
    output logic              enable_sampling_cancel,
    output logic              enable_out,
    output logic [63:0]       double_out,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err,
    output logic [31:0]       iteration
);

    localparam int                SC_W          = $clog2(WARMUP_ADAPT + 1);
    localparam int                TW            = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0]   LP_WARM_LAG   = SC_W'(WARMUP_LAG);
    localparam logic [SC_W-1:0]   LP_WARM_ADAPT = SC_W'(WARMUP_ADAPT);
    localparam logic [TW-1:0]     LP_EN_PULSE   = TW'(EN_PULSE);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt_prev;
    logic              r_mode;
    logic [SC_W-1:0]   r_sample_count;
    logic              r_enable_conv, r_enable_lag, r_enable_adapt, r_enable_cancel;
    logic              r_en_samp_lag, r_en_samp_adapt;
    logic              r_enable_out, r_busy, r_overrun, r_timeout_err;
    logic [63:0]       r_double_out;
    logic [31:0]       r_iteration;

    logic              w_tick, w_load, w_ready_proc, w_timeout_evt;
    logic              w_pulse_done, w_wait_ok, w_timed_out;

    // A tick is the counter landing on zero; a counter parked at zero ticks once
    assign w_tick       = (sampling_cycle_counter == '0) && (r_cnt_prev != '0);
    assign w_ready_proc = (r_mode == MODE_ADAPT) ? ready_adapt : ready_cancel;
    assign w_load       = (w_state_nxt != r_state);
    // Only a wait state that gives up without a qualified ready flags a timeout
    assign w_timeout_evt = is_wait_state(r_state) && (w_state_nxt == S_IDLE);

    seq_stage_timer #(
        .MIN_WAIT (MIN_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .clk_operation (clk_operation),
        .rst           (rst),
        .i_load        (w_load),
        .i_limit       (LP_EN_PULSE),
        .o_pulse_done  (w_pulse_done),
        .o_wait_ok     (w_wait_ok),
        .o_timed_out   (w_timed_out)
    );

    // Next-state decision; a qualified ready beats a timeout in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_tick) w_state_nxt = S_CONV_EN;
            S_CONV_EN:   if (w_pulse_done) w_state_nxt = S_CONV_WAIT;
            S_CONV_WAIT: if (w_wait_ok && ready_conv) w_state_nxt = S_LAG_EN;
                         else if (w_timed_out) w_state_nxt = S_IDLE;
            S_LAG_EN:    if (w_pulse_done) w_state_nxt = S_LAG_WAIT;
            S_LAG_WAIT:  if (w_wait_ok && ready_lag) w_state_nxt = S_PROC_EN;
                         else if (w_timed_out) w_state_nxt = S_IDLE;
            S_PROC_EN:   if (w_pulse_done) w_state_nxt = S_PROC_WAIT;
            S_PROC_WAIT: if (w_wait_ok && w_ready_proc) w_state_nxt = S_OUTPUT;
                         else if (w_timed_out) w_state_nxt = S_IDLE;
            S_OUTPUT:    w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state plus every output, registered from the next state so enables track it
    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt_prev      <= '0;
            r_mode          <= MODE_CANCEL;
            r_sample_count  <= '0;
            r_enable_conv   <= 1'b0;
            r_enable_lag    <= 1'b0;
            r_enable_adapt  <= 1'b0;
            r_enable_cancel <= 1'b0;
            r_en_samp_lag   <= 1'b0;
            r_en_samp_adapt <= 1'b0;
            r_enable_out    <= 1'b0;
            r_busy          <= 1'b0;
            r_overrun       <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_double_out    <= '0;
            r_iteration     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt_prev <= sampling_cycle_counter;

            if (w_tick && (r_state == S_IDLE)) begin
                r_mode <= adapt_mode;
                if (r_sample_count != LP_WARM_ADAPT) begin
                    r_sample_count <= r_sample_count + SC_W'(1);
                end
            end

            r_enable_conv   <= (w_state_nxt == S_CONV_EN);
            r_enable_lag    <= (w_state_nxt == S_LAG_EN);
            r_enable_adapt  <= (w_state_nxt == S_PROC_EN) && (r_mode == MODE_ADAPT);
            r_enable_cancel <= (w_state_nxt == S_PROC_EN) && (r_mode == MODE_CANCEL);
            r_enable_out    <= (w_state_nxt == S_OUTPUT);
            r_busy          <= (w_state_nxt != S_IDLE);

            r_en_samp_lag   <= (r_sample_count >= LP_WARM_LAG);
            r_en_samp_adapt <= (r_sample_count >= LP_WARM_ADAPT);

            if (w_state_nxt == S_OUTPUT) begin
                r_double_out <= (r_mode == MODE_ADAPT) ? e : signal_without_echo;
                if (r_mode == MODE_ADAPT) begin
                    r_iteration <= r_iteration + 32'd1;
                end
            end

            // Setting beats clearing so an event coincident with clear_err is kept
            if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
            else if (clear_err)                r_overrun <= 1'b0;
            if (w_timeout_evt)                 r_timeout_err <= 1'b1;
            else if (clear_err)                r_timeout_err <= 1'b0;
        end
    end

    assign enable_conv            = r_enable_conv;
    assign enable_lag             = r_enable_lag;
    assign enable_adapt           = r_enable_adapt;
    assign enable_cancel          = r_enable_cancel;
    assign enable_sampling_lag    = r_en_samp_lag;
    assign enable_sampling_cancel = r_en_samp_lag;
    assign enable_sampling_adapt  = r_en_samp_adapt;
    assign enable_out             = r_enable_out;
    assign double_out             = r_double_out;
    assign busy                   = r_busy;
    assign overrun                = r_overrun;
    assign timeout_err            = r_timeout_err;
    assign iteration              = r_iteration;

endmodule

// File: tb/tb_echo_pipeline_sequencer.sv
// Directed-plus-random bench for echo_pipeline_sequencer against a timeline model.
// The model derives each stage's start edge from pulse length, ready guard and timeout.
// Outputs are sampled 1 time unit after each rising edge.
module tb_echo_pipeline_sequencer;

    localparam int EN_PULSE = 2;
    localparam int MIN_WAIT = 2;
    localparam int TIMEOUT  = 1500;
    localparam int NEVER    = 100000;
    localparam int EARLY    = -1000;

    logic        clk_operation, rst;
    logic [12:0] sampling_cycle_counter;
    logic        adapt_mode, clear_err;
    logic        ready_conv, ready_lag, ready_adapt, ready_cancel;
    logic [63:0] e, signal_without_echo;
    logic        enable_conv, enable_lag, enable_adapt, enable_cancel;
    logic        enable_sampling_lag, enable_sampling_adapt, enable_sampling_cancel;
    logic        enable_out, busy, overrun, timeout_err;
    logic [63:0] double_out;
    logic [31:0] iteration;

    echo_pipeline_sequencer dut (
        .clk_operation          (clk_operation),
        .rst                    (rst),
        .sampling_cycle_counter (sampling_cycle_counter),
        .adapt_mode             (adapt_mode),
        .clear_err              (clear_err),
        .ready_conv             (ready_conv),
        .ready_lag              (ready_lag),
        .ready_adapt            (ready_adapt),
        .ready_cancel           (ready_cancel),
        .e                      (e),
        .signal_without_echo    (signal_without_echo),
        .enable_conv            (enable_conv),
        .enable_lag             (enable_lag),
        .enable_adapt           (enable_adapt),
        .enable_cancel          (enable_cancel),
        .enable_sampling_lag    (enable_sampling_lag),
        .enable_sampling_adapt  (enable_sampling_adapt),
        .enable_sampling_cancel (enable_sampling_cancel),
        .enable_out             (enable_out),
        .double_out             (double_out),
        .busy                   (busy),
        .overrun                (overrun),
        .timeout_err            (timeout_err),
        .iteration              (iteration)
    );

    initial begin
        clk_operation = 1'b0;
        forever #5 clk_operation = ~clk_operation;
    end

    int cyc = 0;
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int r_cv, r_lg, r_ad, r_cn;          // absolute edge after which each ready is driven high
    logic [31:0] m_iter;
    int          m_cnt;
    logic [63:0] m_dbl;
    logic        m_ovr, m_to;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] nz();
        return 13'($urandom_range(8191, 1));
    endfunction

    task automatic upd_ready();
        ready_conv   = (cyc >= r_cv);
        ready_lag    = (cyc >= r_lg);
        ready_adapt  = (cyc >= r_ad);
        ready_cancel = (cyc >= r_cn);
    endtask

    task automatic step();
        @(posedge clk_operation);
        cyc++;
        #1;
        upd_ready();
    endtask

    // Edge at which a stage leaves its wait, or -1 when it times out instead
    function automatic int stage_exit(input int en_start, input int ready_edge);
        int earliest = en_start + EN_PULSE + MIN_WAIT;
        int ex = (ready_edge > earliest) ? ready_edge : earliest;
        if (ex > en_start + EN_PULSE + TIMEOUT) return -1;
        return ex;
    endfunction

    // One tick; ready offsets are relative to the tick edge (ready first seen one edge later)
    task automatic run_sample(input string nm, input logic mode, input int rcv, input int rlg,
                              input int rad, input int rcn, input int hold0, input int xtick,
                              input logic [63:0] ev, input logic [63:0] sv);
        int t0, cx, lx, px, to_edge, ex_bfall, ex_to;
        int f_cv = -1, n_cv = 0, f_lg = -1, n_lg = 0, f_ad = -1, n_ad = 0;
        int f_cn = -1, n_cn = 0, f_out = -1, n_out = 0, f_to = -1, bfall = -1;
        bit seen_busy = 0;
        adapt_mode = mode; e = ev; signal_without_echo = sv;
        t0 = cyc + 1;
        r_cv = t0 + rcv; r_lg = t0 + rlg; r_ad = t0 + rad; r_cn = t0 + rcn;
        upd_ready();
        sampling_cycle_counter = '0;
        for (int k = 0; k < 5000; k++) begin
            step();
            if (k == hold0) sampling_cycle_counter = nz();
            if (k == 0) adapt_mode = ~mode;
            if (xtick > 0 && cyc == t0 + xtick - 1) begin sampling_cycle_counter = '0; clear_err = 1'b1; end
            if (xtick > 0 && cyc == t0 + xtick) begin sampling_cycle_counter = nz(); clear_err = 1'b0; end
            if (enable_conv)   begin if (n_cv == 0) f_cv = cyc; n_cv++; end
            if (enable_lag)    begin if (n_lg == 0) f_lg = cyc; n_lg++; end
            if (enable_adapt)  begin if (n_ad == 0) f_ad = cyc; n_ad++; end
            if (enable_cancel) begin if (n_cn == 0) f_cn = cyc; n_cn++; end
            if (enable_out)    begin if (n_out == 0) f_out = cyc; n_out++; end
            if (timeout_err && f_to < 0) f_to = cyc;
            if (busy) seen_busy = 1;
            else if (seen_busy) begin bfall = cyc; break; end
        end
        // Timeline model
        lx = -1; px = -1; to_edge = -1;
        cx = stage_exit(t0, t0 + rcv + 1);
        if (cx < 0) to_edge = t0 + EN_PULSE + TIMEOUT;
        else begin
            lx = stage_exit(cx, t0 + rlg + 1);
            if (lx < 0) to_edge = cx + EN_PULSE + TIMEOUT;
            else begin
                px = stage_exit(lx, t0 + (mode ? rad : rcn) + 1);
                if (px < 0) to_edge = lx + EN_PULSE + TIMEOUT;
            end
        end
        ex_bfall = (px >= 0) ? px + 1 : to_edge;
        ex_to    = m_to ? t0 : to_edge;
        if (m_cnt < 4) m_cnt++;
        if (px >= 0) begin
            m_dbl = mode ? ev : sv;
            if (mode) m_iter = m_iter + 32'd1;
        end
        if (to_edge >= 0) m_to = 1'b1;
        if (xtick > 0) m_ovr = 1'b1;
        check({nm, " conv_rise"},   f_cv, t0);
        check({nm, " conv_len"},    n_cv, EN_PULSE);
        check({nm, " lag_rise"},    f_lg, (cx < 0) ? -1 : cx);
        check({nm, " lag_len"},     n_lg, (cx < 0) ? 0 : EN_PULSE);
        check({nm, " adapt_rise"},  f_ad, (mode && lx >= 0) ? lx : -1);
        check({nm, " adapt_len"},   n_ad, (mode && lx >= 0) ? EN_PULSE : 0);
        check({nm, " cancel_rise"}, f_cn, (!mode && lx >= 0) ? lx : -1);
        check({nm, " cancel_len"},  n_cn, (!mode && lx >= 0) ? EN_PULSE : 0);
        check({nm, " out_edge"},    f_out, px);
        check({nm, " out_count"},   n_out, (px >= 0) ? 1 : 0);
        check({nm, " busy_fall"},   bfall, ex_bfall);
        check({nm, " timeout_edge"}, f_to, ex_to);
        check({nm, " double_out"},  double_out, m_dbl);
        check({nm, " iteration"},   iteration, m_iter);
        check({nm, " overrun"},     overrun, m_ovr);
        check({nm, " timeout_err"}, timeout_err, m_to);
        check({nm, " es_lag"},      enable_sampling_lag, m_cnt >= 2);
        check({nm, " es_cancel"},   enable_sampling_cancel, m_cnt >= 2);
        check({nm, " es_adapt"},    enable_sampling_adapt, m_cnt >= 4);
    endtask

    task automatic pulse_clear(input string nm);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        m_ovr = 1'b0; m_to = 1'b0;
        check({nm, " overrun_cleared"}, overrun, m_ovr);
        check({nm, " timeout_cleared"}, timeout_err, m_to);
    endtask

    initial begin
        int t0;
        rst = 1'b1; clear_err = 1'b0; adapt_mode = 1'b0;
        sampling_cycle_counter = 13'd5; e = '0; signal_without_echo = '0;
        r_cv = NEVER; r_lg = NEVER; r_ad = NEVER; r_cn = NEVER;
        upd_ready();
        m_iter = '0; m_cnt = 0; m_dbl = '0; m_ovr = 1'b0; m_to = 1'b0;
        repeat (3) step();
        check("rst enable_conv", enable_conv, 0);
        check("rst enable_out", enable_out, 0);
        check("rst busy", busy, 0);
        check("rst double_out", double_out, 64'h0);
        check("rst iteration", iteration, 0);
        check("rst flags", {overrun, timeout_err}, 0);
        check("rst warmup", {enable_sampling_lag, enable_sampling_adapt, enable_sampling_cancel}, 0);
        rst = 1'b0;
        step();

        // Best case adapt path
        run_sample("adapt", 1'b1, EARLY, EARLY, EARLY, EARLY, 0, 0,
                   {$urandom, $urandom}, {$urandom, $urandom});
        // Second tick during LAG_WAIT, with clear_err in the same cycle
        run_sample("overrun", 1'($urandom_range(1, 0)), EARLY, 40, EARLY, EARLY, 0, 8,
                   {$urandom, $urandom}, {$urandom, $urandom});
        pulse_clear("overrun");
        // Cancel path, ready_cancel 50 cycles after enable_cancel falls, counter parked at 0
        run_sample("cancel", 1'b0, EARLY, EARLY, EARLY, 59, 20, 0,
                   {$urandom, $urandom}, 64'h3FF0000000000000);
        for (int i = 0; i < 6; i++) begin
            run_sample($sformatf("rnd%0d", i), 1'($urandom_range(1, 0)),
                       $urandom_range(45, 0) - 5, $urandom_range(45, 0) - 5,
                       $urandom_range(45, 0) - 5, $urandom_range(45, 0) - 5, 0, 0,
                       {$urandom, $urandom}, {$urandom, $urandom});
        end
        // ready_conv stuck low
        run_sample("timeout", 1'($urandom_range(1, 0)), NEVER, EARLY, EARLY, EARLY, 0, 0,
                   {$urandom, $urandom}, {$urandom, $urandom});
        pulse_clear("timeout");

        // Asynchronous reset during PROC_EN
        adapt_mode = 1'b1;
        t0 = cyc + 1;
        r_cv = EARLY; r_lg = EARLY; r_ad = EARLY; r_cn = EARLY;
        upd_ready();
        sampling_cycle_counter = '0;
        step();
        sampling_cycle_counter = nz();
        repeat (EN_PULSE * 4) step();
        check("arst pre enable_adapt", enable_adapt, 1);
        check("arst pre edge", cyc, t0 + 8);
        #2;
        rst = 1'b1;
        #1;
        check("arst enable_adapt", enable_adapt, 0);
        check("arst busy", busy, 0);
        check("arst iteration", iteration, 0);
        check("arst double_out", double_out, 64'h0);
        check("arst warmup", {enable_sampling_lag, enable_sampling_adapt}, 0);
        repeat (2) step();
        rst = 1'b0;
        m_iter = '0; m_cnt = 0; m_dbl = '0; m_ovr = 1'b0; m_to = 1'b0;
        step();
        run_sample("post_rst", 1'b1, EARLY, EARLY, EARLY, EARLY, 0, 0,
                   {$urandom, $urandom}, {$urandom, $urandom});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
